sr_excitation_encoder: RTL and testbench
========================================

Name: sr_excitation_encoder

Overview:
- Drives a bank of positive-edge SR storage flops from the command side. It accepts a target level word over a valid/ready handshake.
- It computes per-bit set/reset excitation against a shadow copy of the stored state. It then issues s/r pulses that never contain the illegal s=1,r=1 combination.
- It sits upstream of an SR flop bank and is the single owner of that bank's s/r inputs.

Parameters:
- W, 4, number of SR channels (width of target, s, r, shadow_q); min 1.
- PULSE_CYCLES, 1, cycles each s/r command is held asserted; min 1.
- GAP_CYCLES, 1, cycles of forced s=r=0 (hold) after each pulse before the next accept; 0 allowed.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tgt_valid  input  1  target word offered.
- tgt_data  input  W  requested stored level per channel.
- tgt_ready  output  1  encoder can accept; high only in IDLE.
- s  output  W  set excitation to SR bank, registered.
- r  output  W  reset excitation to SR bank, registered.
- shadow_q  output  W  encoder's model of the SR bank contents, registered.
- busy  output  1  high in PULSE or GAP.
- cmd_count  output  8  number of non-no-op commands issued; wraps 255->0.

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, s=0, r=0, shadow_q=0, cmd_count=0, busy=0. tgt_ready=1 once rst_n is high.
- States: IDLE, PULSE, GAP. A 16-bit down-counter times PULSE and GAP.
- Accept occurs at a rising edge with tgt_valid&tgt_ready. The word is latched; the encoder computes set=tgt_data&~shadow_q and rst=~tgt_data&shadow_q.
- No-op accept (set==0 and rst==0): word consumed, stay IDLE, s/r stay 0, cmd_count unchanged, tgt_ready stays 1.
- Effective accept, edge E0:
  - State->PULSE; s<=set, r<=rst; cmd_count increments.
  - s/r hold for exactly PULSE_CYCLES cycles.
  - Per bit, s&r is never 1 (guaranteed by construction; verify by assertion).
- shadow_q<=latched target at the first rising edge after E0. This matches the edge where the downstream flop captures.
- After PULSE_CYCLES edges: s<=0, r<=0.
  - GAP_CYCLES>0: state->GAP for GAP_CYCLES cycles, then IDLE.
  - GAP_CYCLES==0: state->IDLE directly.
- tgt_ready=0 for PULSE_CYCLES+GAP_CYCLES cycles after an effective accept. With defaults, ready is low after E0, high again after E2, and the next accept is possible at E3.
- Bits unchanged between shadow and target get s=r=0 (hold) throughout.
- tgt_data changes while busy are ignored. tgt_valid held high while busy is not an accept.
- Reset asserted mid-PULSE: s/r drop to 0 immediately (async). shadow_q=0; the downstream bank is reset by the same rst_n.
- cmd_count wraps modulo 256 with no flag.

Test Plan:
- Reset then idle: rst_n low 2 cycles, release -> s=0000, r=0000, shadow_q=0000, tgt_ready=1, busy=0, cmd_count=0.
- Set from zero: accept 1010 at E0 -> s=1010, r=0000 for 1 cycle; shadow_q=1010 after E1; cycle E1-E2 s=r=0, busy=1; tgt_ready=1 after E2; cmd_count=1.
- Mixed set/reset: from shadow 1010, accept 0110 -> s=0100, r=1000 for 1 cycle, never s&r!=0, shadow_q=0110, cmd_count=2.
- No-op and busy blocking: accept 0110 with shadow 0110 -> no pulse, ready stays 1. Then accept 1111 and hold valid with 0000 during busy -> only 1111 applied (s=1001), 0000 accepted at E3 -> r=1111.
- Parameter sweep PULSE_CYCLES=3, GAP_CYCLES=0: accept 0001 -> s=0001 exactly 3 cycles, ready returns the cycle after s drops, no GAP state.
- Reset mid-pulse (PULSE_CYCLES=3): assert rst_n low during 2nd pulse cycle -> s=r=0, shadow_q=0, cmd_count=0 immediately, before next clk edge; after release ready=1.

Source files
------------

// File: rtl/sr_excitation_encoder.sv
// Set/reset excitation encoder for a bank of positive-edge SR flops.
// Compares a requested level word with a shadow of the bank, then issues
// one s/r pulse (never s=r=1 per bit) followed by an optional hold gap.
module sr_excitation_encoder #(
  parameter int unsigned W            = 4,
  parameter int unsigned PULSE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tgt_valid,
  input  logic [W-1:0] tgt_data,
  output logic         tgt_ready,
  output logic [W-1:0] s,
  output logic [W-1:0] r,
  output logic [W-1:0] shadow_q,
  output logic         busy,
  output logic [7:0]   cmd_count
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned CNT_LOAD_PULSE = (PULSE_CYCLES > 0) ? PULSE_CYCLES - 1 : 0;
  localparam int unsigned CNT_LOAD_GAP   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam bit          HAS_GAP        = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [W-1:0]       latched, latched_n;
  logic               shadow_pend, shadow_pend_n;
  logic [W-1:0]       s_n, r_n, shadow_n;
  logic               ready_q, ready_n;
  logic               busy_n;
  logic [7:0]         cmd_count_n;

  logic [W-1:0]       set_c;
  logic [W-1:0]       rst_c;
  logic               accept_c;

  assign tgt_ready = ready_q;

  // Per-bit excitation against the shadow copy; set and rst are disjoint.
  always_comb begin
    set_c    = tgt_data & ~shadow_q;
    rst_c    = ~tgt_data & shadow_q;
    accept_c = tgt_valid & ready_q;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    latched_n     = latched;
    shadow_pend_n = shadow_pend;
    s_n           = s;
    r_n           = r;
    shadow_n      = shadow_q;
    ready_n       = ready_q;
    busy_n        = busy;
    cmd_count_n   = cmd_count;

    unique case (state)
      ST_IDLE: begin
        if (accept_c) begin
          latched_n = tgt_data;
          if ((set_c | rst_c) != '0) begin
            state_n       = ST_PULSE;
            s_n           = set_c;
            r_n           = rst_c;
            cnt_n         = CNT_W'(CNT_LOAD_PULSE);
            shadow_pend_n = 1'b1;
            ready_n       = 1'b0;
            busy_n        = 1'b1;
            cmd_count_n   = cmd_count + 8'd1;
          end
        end
      end

      ST_PULSE: begin
        // Shadow tracks the bank at the edge where the bank captures s/r.
        if (shadow_pend) begin
          shadow_n      = latched;
          shadow_pend_n = 1'b0;
        end
        if (cnt == '0) begin
          s_n = '0;
          r_n = '0;
          if (HAS_GAP) begin
            state_n = ST_GAP;
            cnt_n   = CNT_W'(CNT_LOAD_GAP);
          end else begin
            state_n = ST_IDLE;
            ready_n = 1'b1;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt == '0) begin
          state_n = ST_IDLE;
          ready_n = 1'b1;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_n       = ST_IDLE;
        s_n           = '0;
        r_n           = '0;
        shadow_pend_n = 1'b0;
        ready_n       = 1'b1;
        busy_n        = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      latched     <= '0;
      shadow_pend <= 1'b0;
      s           <= '0;
      r           <= '0;
      shadow_q    <= '0;
      ready_q     <= 1'b1;
      busy        <= 1'b0;
      cmd_count   <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      latched     <= latched_n;
      shadow_pend <= shadow_pend_n;
      s           <= s_n;
      r           <= r_n;
      shadow_q    <= shadow_n;
      ready_q     <= ready_n;
      busy        <= busy_n;
      cmd_count   <= cmd_count_n;
    end
  end

  // The SR bank must never see s=r=1 on any channel.
  a_no_illegal_sr: assert property (@(posedge clk) disable iff (!rst_n) ((s & r) == '0));

endmodule

// File: tb/tb_sr_excitation_encoder.sv
// Directed bench: default-parameter encoder (A) and a PULSE=3/GAP=0 encoder (B).
module tb_sr_excitation_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_valid = 1'b0;
  logic [3:0] a_data = '0;
  logic       a_ready, a_busy;
  logic [3:0] a_s, a_r, a_sh;
  logic [7:0] a_cnt;

  logic       b_valid = 1'b0;
  logic [3:0] b_data = '0;
  logic       b_ready, b_busy;
  logic [3:0] b_s, b_r, b_sh;
  logic [7:0] b_cnt;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  sr_excitation_encoder dut_a (
    .clk(clk), .rst_n(rst_n), .tgt_valid(a_valid), .tgt_data(a_data),
    .tgt_ready(a_ready), .s(a_s), .r(a_r), .shadow_q(a_sh),
    .busy(a_busy), .cmd_count(a_cnt)
  );

  sr_excitation_encoder #(.W(4), .PULSE_CYCLES(3), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .tgt_valid(b_valid), .tgt_data(b_data),
    .tgt_ready(b_ready), .s(b_s), .r(b_r), .shadow_q(b_sh),
    .busy(b_busy), .cmd_count(b_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // s and r must be disjoint on both instances every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_s_and_r", 32'(a_s & a_r), 32'd0);
      chk("b_s_and_r", 32'(b_s & b_r), 32'd0);
    end
  end

  typedef struct {
    logic [3:0] data;
    logic [3:0] es;
    logic [3:0] er;
    logic [3:0] esh;
    logic [7:0] ec;
    bit         noop;
  } vec_t;

  // One accept on A, starting and ending at a negedge with A idle.
  task automatic txn(input logic [3:0] d, input logic [3:0] es, input logic [3:0] er,
                     input logic [3:0] esh, input logic [7:0] ec, input bit noop);
    chk("pre_ready", 32'(a_ready), 32'd1);
    a_valid = 1'b1;
    a_data  = d;
    @(negedge clk);
    a_valid = 1'b0;
    if (noop) begin
      chk("noop_s", 32'(a_s), 32'd0);
      chk("noop_r", 32'(a_r), 32'd0);
      chk("noop_ready", 32'(a_ready), 32'd1);
      chk("noop_busy", 32'(a_busy), 32'd0);
      chk("noop_shadow", 32'(a_sh), 32'(esh));
      chk("noop_count", 32'(a_cnt), 32'(ec));
    end else begin
      chk("e0_s", 32'(a_s), 32'(es));
      chk("e0_r", 32'(a_r), 32'(er));
      chk("e0_ready", 32'(a_ready), 32'd0);
      chk("e0_busy", 32'(a_busy), 32'd1);
      chk("e0_count", 32'(a_cnt), 32'(ec));
      @(negedge clk);
      chk("e1_s", 32'(a_s), 32'd0);
      chk("e1_r", 32'(a_r), 32'd0);
      chk("e1_shadow", 32'(a_sh), 32'(esh));
      chk("e1_busy", 32'(a_busy), 32'd1);
      chk("e1_ready", 32'(a_ready), 32'd0);
      @(negedge clk);
      chk("e2_ready", 32'(a_ready), 32'd1);
      chk("e2_busy", 32'(a_busy), 32'd0);
    end
  endtask

  vec_t tbl[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{data: 4'b1010, es: 4'b1010, er: 4'b0000, esh: 4'b1010, ec: 8'd1, noop: 1'b0};
    tbl[1] = '{data: 4'b0110, es: 4'b0100, er: 4'b1000, esh: 4'b0110, ec: 8'd2, noop: 1'b0};
    tbl[2] = '{data: 4'b0110, es: 4'b0000, er: 4'b0000, esh: 4'b0110, ec: 8'd2, noop: 1'b1};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_a_s", 32'(a_s), 32'd0);
    chk("rst_a_r", 32'(a_r), 32'd0);
    chk("rst_a_shadow", 32'(a_sh), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_count", 32'(a_cnt), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);

    for (int i = 0; i < 3; i++)
      txn(tbl[i].data, tbl[i].es, tbl[i].er, tbl[i].esh, tbl[i].ec, tbl[i].noop);

    // Valid held through busy: the 0000 offered while busy waits until E3.
    a_valid = 1'b1;
    a_data  = 4'b1111;
    @(negedge clk);
    a_data = 4'b0000;
    chk("hold_e0_s", 32'(a_s), 32'b1001);
    chk("hold_e0_r", 32'(a_r), 32'd0);
    chk("hold_e0_count", 32'(a_cnt), 32'd3);
    @(negedge clk);
    chk("hold_e1_shadow", 32'(a_sh), 32'b1111);
    chk("hold_e1_s", 32'(a_s), 32'd0);
    chk("hold_e1_r", 32'(a_r), 32'd0);
    @(negedge clk);
    chk("hold_e2_ready", 32'(a_ready), 32'd1);
    chk("hold_e2_r", 32'(a_r), 32'd0);
    chk("hold_e2_count", 32'(a_cnt), 32'd3);
    @(negedge clk);
    a_valid = 1'b0;
    chk("hold_e3_r", 32'(a_r), 32'b1111);
    chk("hold_e3_s", 32'(a_s), 32'd0);
    chk("hold_e3_count", 32'(a_cnt), 32'd4);
    @(negedge clk);
    chk("hold_e4_shadow", 32'(a_sh), 32'd0);
    @(negedge clk);
    chk("hold_e5_ready", 32'(a_ready), 32'd1);

    // Drive cmd_count from 4 through 255 and wrap to 0.
    for (int i = 0; i < 252; i++) begin
      if (i % 2 == 0) txn(4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'(4 + i + 1), 1'b0);
      else            txn(4'b0000, 4'b0000, 4'b0001, 4'b0000, 8'(4 + i + 1), 1'b0);
    end
    chk("wrap_count", 32'(a_cnt), 32'd0);

    // B: three-cycle pulse, no gap.
    b_valid = 1'b1;
    b_data  = 4'b0001;
    @(negedge clk);
    b_valid = 1'b0;
    chk("b_e0_s", 32'(b_s), 32'b0001);
    chk("b_e0_ready", 32'(b_ready), 32'd0);
    chk("b_e0_count", 32'(b_cnt), 32'd1);
    @(negedge clk);
    chk("b_e1_s", 32'(b_s), 32'b0001);
    chk("b_e1_shadow", 32'(b_sh), 32'b0001);
    chk("b_e1_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    chk("b_e2_s", 32'(b_s), 32'b0001);
    chk("b_e2_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    chk("b_e3_s", 32'(b_s), 32'd0);
    chk("b_e3_ready", 32'(b_ready), 32'd1);
    chk("b_e3_busy", 32'(b_busy), 32'd0);

    // B: reset in the second pulse cycle clears outputs before any clock edge.
    b_valid = 1'b1;
    b_data  = 4'b0010;
    @(negedge clk);
    b_valid = 1'b0;
    chk("b2_e0_s", 32'(b_s), 32'b0010);
    chk("b2_e0_r", 32'(b_r), 32'b0001);
    @(negedge clk);
    chk("b2_e1_s", 32'(b_s), 32'b0010);
    chk("b2_e1_shadow", 32'(b_sh), 32'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    chk("b_async_s", 32'(b_s), 32'd0);
    chk("b_async_r", 32'(b_r), 32'd0);
    chk("b_async_shadow", 32'(b_sh), 32'd0);
    chk("b_async_count", 32'(b_cnt), 32'd0);
    chk("b_async_busy", 32'(b_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("b_post_ready", 32'(b_ready), 32'd1);
    chk("b_post_s", 32'(b_s), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
